vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised raster timing generator: produces H/V sync, data-enable, blanking flags,
//   clamped pixel coordinates, frame/line markers and a frame counter for any VGA-class mode.
// - Sits between the pixel-clock domain and the pixel renderer (sprite/background logic),
//   replacing the fixed 640x480 counter with a configurable mode, pixel strobe and registered outputs.
// PARAMETERS
// H_ACTIVE  640  visible pixels per line
// H_FP      16   horizontal front porch (pixels)
// H_SYNC    96   horizontal sync width (pixels)
// H_BP      48   horizontal back porch (pixels); H_TOTAL = sum of the four = 800
// V_ACTIVE  480  visible lines per frame
// V_FP      10   vertical front porch (lines)
// V_SYNC    2    vertical sync width (lines)
// V_BP      33   vertical back porch (lines); V_TOTAL = sum of the four = 525
// H_POL     0    hsync active level (0 = active-low)
// V_POL     0    vsync active level (0 = active-low)
// CW        10   coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
// FRAME_W   16   frame counter width
// PORTS
// i_clk       in   1        clock
// i_rst       in   1        asynchronous active-high reset
// i_pix_stb   in   1        pixel strobe; raster advances one pixel per cycle it is high
// o_hs        out  1        horizontal sync (polarity per H_POL)
// o_vs        out  1        vertical sync (polarity per V_POL)
// o_de        out  1        1 when presented pixel is in the active area
// o_hblank    out  1        1 when h position >= H_ACTIVE
// o_vblank    out  1        1 when v position >= V_ACTIVE
// o_x         out  CW       pixel x, clamped to 0..H_ACTIVE-1
// o_y         out  CW       pixel y, clamped to 0..V_ACTIVE-1
// o_sof       out  1        1-cycle pulse when pixel (0,0) is presented
// o_eol       out  1        1-cycle pulse when last pixel of any line (h=H_TOTAL-1) is presented
// o_frame     out  FRAME_W  completed-frame count
// BEHAVIOUR
// - Internal counters h (0..H_TOTAL-1), v (0..V_TOTAL-1) name the next pixel to present.
// - On a cycle with i_pix_stb=1: all outputs register the decode of (h,v); then h increments;
//   at h=H_TOTAL-1, h->0 and v increments; at (H_TOTAL-1,V_TOTAL-1), v->0 and o_frame+1 (wraps).
// - Latency: pixel (h,v) appears on outputs the cycle after the strobe that consumed it.
// - i_pix_stb=0: counters and o_hs/o_vs/o_de/o_hblank/o_vblank/o_x/o_y/o_frame hold;
//   o_sof and o_eol drop to 0 (pulses are never longer than one cycle).
// - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; else inactive level.
// - vsync active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the full line (all h).
// - o_de = (h<H_ACTIVE)&&(v<V_ACTIVE); o_x = min(h,H_ACTIVE-1); o_y = min(v,V_ACTIVE-1).
// - Reset (async, any time incl. mid-line): h=v=0, o_frame=0, o_de=o_sof=o_eol=0,
//   o_hblank=o_vblank=0, o_x=o_y=0, o_hs=~H_POL, o_vs=~V_POL. First strobe after
//   release presents (0,0) with o_de=1, o_sof=1.
// - All outputs are flops; no combinational path from i_pix_stb to any output.
// - o_frame increments on the clock edge of the strobe consuming (H_TOTAL-1,V_TOTAL-1),
//   so it is visible one cycle before o_sof of the next frame.
// TESTING
// Small mode: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), polarities 0, i_pix_stb tied 1.
// 1 Reset release -> cycle 1: o_de=1,o_sof=1,o_x=0,o_y=0; o_sof low on cycles 2..128.
// 2 Line 0 -> o_hs=0 on cycles 11..13 (h=10..12), 1 elsewhere; o_de=1 cycles 1..8;
//   o_x=7 held cycles 8..16; o_eol=1 on cycle 16 only.
// 3 Full frame -> o_vs=0 for lines v=5,6 (32 cycles); o_vblank=1 lines 4..7; o_y clamps at 3;
//   o_frame 0->1 at frame end, o_sof again at cycle 129.
// 4 i_pix_stb = 1-of-4 pattern -> identical output sequence stretched 4x; all
//   level outputs hold between strobes; o_sof/o_eol exactly 1 cycle wide.
// 5 Assert i_rst at h=5,v=2 between clock edges -> outputs reach reset values without
//   a clock edge; release -> sequence restarts from (0,0) as in test 1.
// 6 H_POL=1,V_POL=1, FRAME_W=2, run 5 frames -> syncs high in same windows;
//   o_frame sequence 1,2,3,0,1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Configurable raster timing generator: h/v counters advanced by a pixel strobe,
// with every output registered so the renderer sees one clean, aligned pixel stream.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CW       = 10,
    parameter int FRAME_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_stb,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de,
    output logic               o_hblank,
    output logic               o_vblank,
    output logic [CW-1:0]      o_x,
    output logic [CW-1:0]      o_y,
    output logic               o_sof,
    output logic               o_eol,
    output logic [FRAME_W-1:0] o_frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_X_MAX  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_Y_MAX  = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = (H_POL != 0);
    localparam logic          VS_ON    = (V_POL != 0);

    // h/v name the next pixel to present, not the one currently on the outputs
    logic [CW-1:0]      h_q, h_d, v_q, v_d;
    logic [CW-1:0]      x_q, x_d, y_q, y_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic               hblank_q, hblank_d, vblank_q, vblank_d;
    logic               sof_q, sof_d, eol_q, eol_d;

    always_comb begin
        h_d      = h_q;
        v_d      = v_q;
        x_d      = x_q;
        y_d      = y_q;
        frame_d  = frame_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        de_d     = de_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        sof_d    = 1'b0;
        eol_d    = 1'b0;
        if (i_pix_stb) begin
            hs_d     = (h_q >= HS_START && h_q < HS_END) ? HS_ON : ~HS_ON;
            vs_d     = (v_q >= VS_START && v_q < VS_END) ? VS_ON : ~VS_ON;
            de_d     = (h_q < H_ACT) && (v_q < V_ACT);
            hblank_d = (h_q >= H_ACT);
            vblank_d = (v_q >= V_ACT);
            x_d      = (h_q < H_ACT) ? h_q : H_X_MAX;
            y_d      = (v_q < V_ACT) ? v_q : V_Y_MAX;
            sof_d    = (h_q == '0) && (v_q == '0);
            eol_d    = (h_q == H_LAST);
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d     = '0;
                    frame_d = frame_q + FRAME_W'(1);
                end else begin
                    v_d = v_q + CW'(1);
                end
            end else begin
                h_d = h_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_q      <= '0;
            v_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            frame_q  <= '0;
            hs_q     <= ~HS_ON;
            vs_q     <= ~VS_ON;
            de_q     <= 1'b0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            x_q      <= x_d;
            y_q      <= y_d;
            frame_q  <= frame_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
        end
    end

    assign o_hs     = hs_q;
    assign o_vs     = vs_q;
    assign o_de     = de_q;
    assign o_hblank = hblank_q;
    assign o_vblank = vblank_q;
    assign o_x      = x_q;
    assign o_y      = y_q;
    assign o_sof    = sof_q;
    assign o_eol    = eol_q;
    assign o_frame  = frame_q;

endmodule
